// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 character-LCD custom instructions
// (reader and writer): controller state encoding, default bus timing at a
// 50 MHz system clock, register-select codes and the busy-flag bit position.
// -----------------------------------------------------------------------------
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_EN_HIGH = 3'd2,
      ST_EN_LOW  = 3'd3,
      ST_DONE    = 3'd4
   } lcd_state_e;

   // Default bus timing in system clocks (50 MHz).
   localparam int LCD_SETUP_CYCLES   = 5;
   localparam int LCD_EN_HIGH_CYCLES = 25;
   localparam int LCD_EN_LOW_CYCLES  = 25;
   localparam int LCD_POLL_LIMIT     = 2000;

   // Register-select codes.
   localparam logic RS_INSTR = 1'b0;   // busy flag / address counter
   localparam logic RS_DATA  = 1'b1;   // display / CG RAM data

   // Busy flag position within the RS=0 status byte.
   localparam int BUSY_BIT = 7;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// -----------------------------------------------------------------------------
// lcd_phase_timer
// Loadable down-counter used to time the phases of an LCD bus cycle.
// Loading value N makes the terminal-count flag appear N clocks later, so a
// phase of C clocks is produced by loading C-1 when the phase is entered.
// The counter stops at zero and freezes completely while clk_en is low.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   clk_en      in   count/load enable; state holds while low
//   load        in   load load_value on the next enabled edge
//   load_value  in   WIDTH-bit reload value
//   tc          out  terminal count (counter == 0)
// -----------------------------------------------------------------------------
module lcd_phase_timer #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             tc
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clk_en) begin
         if (load) begin
            count_q <= load_value;
         end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign tc = (count_q == '0);

endmodule

// File: rtl/read_lcd.sv
// -----------------------------------------------------------------------------
// read_lcd
// Multi-cycle Nios II custom instruction that performs one HD44780 read
// cycle (status or RAM data), optionally repeating the status read until the
// busy flag clears or a poll limit is reached.
//
// Ports
//   clk              in   system clock (50 MHz)
//   reset            in   asynchronous active-low reset
//   clk_en           in   custom-instruction clock enable; all state holds while low
//   start            in   custom-instruction start, accepted only in IDLE
//   dataA[0]         in   RS for the read (0 = busy/address, 1 = data RAM)
//   dataB[0]         in   busy-poll mode (forces RS = 0)
//   result           out  {timeout, 23'b0, read_byte}, held until the next completion
//   done             out  one-cycle completion pulse
//   read_write       out  LCD R/W (1 while a read cycle is in progress)
//   register_select  out  LCD RS
//   enable_op        out  LCD E
//   data_in          in   LCD D7..D0 from the pads
// -----------------------------------------------------------------------------
module read_lcd
   import lcd_pkg::*;
#(
   parameter int SETUP_CYCLES   = LCD_SETUP_CYCLES,
   parameter int EN_HIGH_CYCLES = LCD_EN_HIGH_CYCLES,
   parameter int EN_LOW_CYCLES  = LCD_EN_LOW_CYCLES,
   parameter int POLL_LIMIT     = LCD_POLL_LIMIT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   output logic [31:0] result,
   output logic        done,
   output logic        read_write,
   output logic        register_select,
   output logic        enable_op,
   input  logic [7:0]  data_in
);

   localparam int MAX_PHASE = max3(SETUP_CYCLES, EN_HIGH_CYCLES, EN_LOW_CYCLES);
   localparam int PW        = $clog2(MAX_PHASE) + 1;
   localparam int CW        = $clog2(POLL_LIMIT) + 1;

   // Timer reload values: a phase of C clocks is loaded with C-1.
   localparam logic [PW-1:0] SETUP_LD   = PW'(SETUP_CYCLES - 1);
   localparam logic [PW-1:0] EN_HIGH_LD = PW'(EN_HIGH_CYCLES - 1);
   localparam logic [PW-1:0] EN_LOW_LD  = PW'(EN_LOW_CYCLES - 1);
   // Poll count holds (reads completed - 1); this value marks the final read.
   localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_LIMIT - 1);

   lcd_state_e      state_q,     state_d;
   logic            rs_q,        rs_d;
   logic            rw_q,        rw_d;
   logic            en_q,        en_d;
   logic            done_q,      done_d;
   logic            poll_q,      poll_d;
   logic            timeout_q,   timeout_d;
   logic [7:0]      read_byte_q, read_byte_d;
   logic [31:0]     result_q,    result_d;
   logic [CW-1:0]   poll_cnt_q,  poll_cnt_d;

   logic            timer_load;
   logic [PW-1:0]   timer_value;
   logic            timer_tc;

   // Only bit 0 of each operand carries information.
   logic unused_operand_bits;
   assign unused_operand_bits = ^{dataA[31:1], dataB[31:1]};

   lcd_phase_timer #(
      .WIDTH (PW)
   ) u_phase_timer (
      .clk        (clk),
      .reset      (reset),
      .clk_en     (clk_en),
      .load       (timer_load),
      .load_value (timer_value),
      .tc         (timer_tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         rs_q        <= RS_INSTR;
         rw_q        <= 1'b0;
         en_q        <= 1'b0;
         done_q      <= 1'b0;
         poll_q      <= 1'b0;
         timeout_q   <= 1'b0;
         read_byte_q <= 8'h00;
         result_q    <= 32'h0;
         poll_cnt_q  <= '0;
      end else if (clk_en) begin
         state_q     <= state_d;
         rs_q        <= rs_d;
         rw_q        <= rw_d;
         en_q        <= en_d;
         done_q      <= done_d;
         poll_q      <= poll_d;
         timeout_q   <= timeout_d;
         read_byte_q <= read_byte_d;
         result_q    <= result_d;
         poll_cnt_q  <= poll_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rs_d        = rs_q;
      rw_d        = rw_q;
      en_d        = en_q;
      done_d      = done_q;
      poll_d      = poll_q;
      timeout_d   = timeout_q;
      read_byte_d = read_byte_q;
      result_d    = result_q;
      poll_cnt_d  = poll_cnt_q;
      timer_load  = 1'b0;
      timer_value = '0;

      case (state_q)
         ST_IDLE: begin
            done_d = 1'b0;
            en_d   = 1'b0;
            rw_d   = 1'b0;
            if (start) begin
               // Busy polling only makes sense against the status register.
               rs_d        = dataB[0] ? RS_INSTR : (dataA[0] ? RS_DATA : RS_INSTR);
               poll_d      = dataB[0];
               poll_cnt_d  = '0;
               rw_d        = 1'b1;
               timer_load  = 1'b1;
               timer_value = SETUP_LD;
               state_d     = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (timer_tc) begin
               en_d        = 1'b1;
               timer_load  = 1'b1;
               timer_value = EN_HIGH_LD;
               state_d     = ST_EN_HIGH;
            end
         end

         ST_EN_HIGH: begin
            // Capture the bus on the same edge that drops E.
            if (timer_tc) begin
               en_d        = 1'b0;
               read_byte_d = data_in;
               timer_load  = 1'b1;
               timer_value = EN_LOW_LD;
               state_d     = ST_EN_LOW;
            end
         end

         ST_EN_LOW: begin
            if (timer_tc) begin
               if (poll_q && read_byte_q[BUSY_BIT]) begin
                  if (poll_cnt_q == POLL_LAST) begin
                     timeout_d = 1'b1;
                     rw_d      = 1'b0;
                     state_d   = ST_DONE;
                  end else begin
                     poll_cnt_d  = poll_cnt_q + 1'b1;
                     timer_load  = 1'b1;
                     timer_value = SETUP_LD;
                     state_d     = ST_SETUP;
                  end
               end else begin
                  timeout_d = 1'b0;
                  rw_d      = 1'b0;
                  state_d   = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            done_d   = 1'b1;
            rw_d     = 1'b0;
            result_d = {timeout_q, 23'b0, read_byte_q};
            state_d  = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign result          = result_q;
   assign done            = done_q;
   assign read_write      = rw_q;
   assign register_select = rs_q;
   assign enable_op       = en_q;

endmodule
